debounce_multi: RTL and testbench

Parametrised N-channel switch debouncer, the next generation of the single-switch debounce/LED path on the 50 MHz board clock. Each channel synchronises a raw mechanical input and normalises its polarity. It then qualifies the input with a per-channel stability counter and emits a debounced level, one-cycle press/release pulses and a press-toggled latch. It sits directly behind the board switch/button pins and feeds LEDs and control logic.

---
 rtl/debounce_multi.sv | 107 ++++++++++
 tb/tb_debounce_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch debouncer with press/release pulses and press-toggled latch
// Ports: clk_50 / reset_n (async, active-low); sw_i raw switches; db_o debounced pressed level;
//        press_o / release_o one-cycle edge pulses; toggle_o flips on each press;
//        hold_o long-press pulse, built only when DEBOUNCE_HOLD_EN is defined (else tied 0).
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int ACTIVE_LOW    = 1,
  parameter int HOLD_CYCLES   = 50000000
) (
  input  logic            clk_50,
  input  logic            reset_n,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] toggle_o,
  output logic [N_CH-1:0] hold_o
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [N_CH-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  typedef enum logic {STABLE, QUALIFY} state_t;
  logic [N_CH-1:0] sync1_q, sync2_q, s;
  logic [N_CH-1:0] db_q, db_d, press_q, press_d, release_q, release_d, toggle_q, toggle_d;
  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  assign s = sync2_q ^ IDLE;
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = STABLE;
      cnt_d[i]   = '0;
      if (s[i] != db_q[i]) begin
        if (state_q[i] == STABLE) begin
          state_d[i] = QUALIFY;
          cnt_d[i]   = CW'(1);
        end else if (cnt_q[i] == LAST) begin
          db_d[i] = s[i];
        end else begin
          state_d[i] = QUALIFY;
          cnt_d[i]   = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = db_d & ~db_q;
    release_d = ~db_d & db_q;
    toggle_d  = toggle_q ^ press_d;
  end
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      db_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= sw_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end
  assign db_o      = db_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
`ifdef DEBOUNCE_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HFIRE = HW'(HOLD_CYCLES - 1);
  logic [HW-1:0]   hcnt_q [N_CH];
  logic [HW-1:0]   hcnt_d [N_CH];
  logic [N_CH-1:0] hold_q, hold_d;
  // Counter saturates at HOLD_CYCLES so the pulse fires once per press;
  // db_d gating suppresses a pulse coinciding with the release edge.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hcnt_d[i] = !db_q[i] ? '0 : (hcnt_q[i] == HMAX) ? HMAX : hcnt_q[i] + 1'b1;
      hold_d[i] = db_q[i] & db_d[i] & (hcnt_q[i] == HFIRE);
    end
  end
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      for (int i = 0; i < N_CH; i++) hcnt_q[i] <= '0;
    end else begin
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
    end
  end
  assign hold_o = hold_q;
`else
  assign hold_o = '0;
`endif
endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;
  localparam int NC = 4;
  localparam int STABLE = 10;
  localparam int HOLD = 40;
  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  logic [NC-1:0] sw = 4'hF;
  logic [NC-1:0] db_o, press_o, release_o, toggle_o, hold_o;
  int n_checks = 0;
  int n_errors = 0;
  bit [NC-1:0] m_s1, m_s2, m_db, m_press, m_rel, m_tog, m_hold;
  int m_run [NC];
  int m_hrun [NC];

  debounce_multi #(.N_CH(NC), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1), .HOLD_CYCLES(HOLD)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .sw_i(sw), .db_o(db_o), .press_o(press_o),
    .release_o(release_o), .toggle_o(toggle_o), .hold_o(hold_o));

  always #10 clk_50 = ~clk_50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: pressed samples go through a 2-cycle pipe; db adopts a sample once it has
  // disagreed with db for STABLE consecutive sampled cycles. hold fires when db has been
  // 1 for HOLD cycles after the press cycle.
  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0; m_rel = '0; m_tog = '0; m_hold = '0;
    for (int c = 0; c < NC; c++) begin m_run[c] = 0; m_hrun[c] = 0; end
  endtask

  task automatic model_step();
    bit [NC-1:0] samp, old;
    samp = m_s2; m_s2 = m_s1; m_s1 = ~sw; old = m_db;
    m_press = '0; m_rel = '0; m_hold = '0;
    for (int c = 0; c < NC; c++) begin
      m_run[c] = (samp[c] != m_db[c]) ? m_run[c] + 1 : 0;
      if (m_run[c] == STABLE) begin
        m_run[c] = 0; m_db[c] = samp[c]; m_press[c] = samp[c]; m_rel[c] = !samp[c];
        m_tog[c] = m_tog[c] ^ samp[c];
      end
`ifdef DEBOUNCE_HOLD_EN
      if (!m_db[c]) m_hrun[c] = 0;
      else if (old[c]) m_hrun[c]++;
      m_hold[c] = m_db[c] && m_hrun[c] == HOLD;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    if (!reset_n) model_reset(); else model_step();
    @(negedge clk_50);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (15) tick();
    n_checks++;
    if ({db_o, press_o, release_o, toggle_o, hold_o} !== 20'h0) begin
      n_errors++; $display("FAIL reset_state got=%h exp=00000", {db_o, press_o, release_o, toggle_o, hold_o});
    end
    reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick(); n_checks++;
      if ({db_o, press_o, release_o, toggle_o, hold_o} !== 20'h0) begin
        n_errors++; $display("FAIL idle cyc=%0d got=%h exp=00000", k, {db_o, press_o, release_o, toggle_o, hold_o});
      end
    end
  endtask

  task automatic test_clean_press();
    int rise = -1, pulses = 0;
    sw[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(); n_checks++;
      if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
        n_errors++; $display("FAIL clean_model k=%0d got=%h exp=%h", k, {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
      end
      if (press_o[0]) begin pulses++; if (rise < 0) rise = k; end
    end
    n_checks++; if (rise !== 12) begin n_errors++; $display("FAIL clean_latency got=%0d exp=12", rise); end
    n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL clean_pulses got=%0d exp=1", pulses); end
    n_checks++; if ({db_o, toggle_o} !== 8'h11) begin n_errors++; $display("FAIL clean_levels got=%h exp=11", {db_o, toggle_o}); end
  endtask

  task automatic test_bounce();
    int rise = -1, pulses = 0;
    for (int pass = 0; pass < 2; pass++) begin
      pulses = 0;
      for (int t = 0; t < 20; t++) begin
        sw[1] = ~sw[1];
        repeat ($urandom_range(1, 5)) begin
          tick(); n_checks++;
          if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
            n_errors++; $display("FAIL bounce_model got=%h exp=%h", {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
          end
          if (press_o[1] || release_o[1]) pulses++;
        end
      end
      sw[1] = (pass == 0) ? 1'b0 : 1'b1;
      for (int k = 1; k <= 30; k++) begin
        tick(); n_checks++;
        if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
          n_errors++; $display("FAIL bounce_settle_model got=%h exp=%h", {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
        end
        if (press_o[1] || release_o[1]) begin pulses++; if (rise < 0) rise = k; end
      end
      if (pass == 0) begin
        n_checks++; if (rise !== 12) begin n_errors++; $display("FAIL bounce_latency got=%0d exp=12", rise); end
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL bounce_press_pulses got=%0d exp=1", pulses); end
        sw[1] = 1'b1;
        repeat (20) tick();
      end else begin
        n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL bounce_reject_pulses got=%0d exp=0", pulses); end
        n_checks++; if (db_o[1] !== 1'b0) begin n_errors++; $display("FAIL bounce_reject_db got=%b exp=0", db_o[1]); end
      end
    end
  endtask

  task automatic test_release_toggle();
    int fall = -1, pulses = 0;
    sw[2] = 1'b0;
    repeat (44) begin
      tick(); n_checks++;
      if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
        n_errors++; $display("FAIL rel_hold_model got=%h exp=%h", {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
      end
    end
    sw[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (release_o[2]) begin pulses++; if (fall < 0) fall = k; end
    end
    n_checks++; if (fall !== 12) begin n_errors++; $display("FAIL release_latency got=%0d exp=12", fall); end
    n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL release_pulses got=%0d exp=1", pulses); end
    n_checks++; if (toggle_o[2] !== 1'b1) begin n_errors++; $display("FAIL toggle_after_release got=%b exp=1", toggle_o[2]); end
    sw[2] = 1'b0;
    repeat (20) tick();
    n_checks++; if ({db_o[2], toggle_o[2]} !== 2'b10) begin n_errors++; $display("FAIL toggle_second_press got=%b exp=10", {db_o[2], toggle_o[2]}); end
    n_checks++;
    if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
      n_errors++; $display("FAIL rel_toggle_model got=%h exp=%h", {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
    end
  endtask

  task automatic test_simultaneous_reset();
    int k0 = -1, k3 = -1, kr = -1, early = 0;
    sw = 4'hF;
    repeat (20) tick();
    sw[0] = 1'b0; sw[3] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_o[0] && k0 < 0) k0 = k;
      if (press_o[3] && k3 < 0) k3 = k;
    end
    n_checks++; if (k0 !== 12 || k3 !== 12) begin n_errors++; $display("FAIL simul_press got=%0d,%0d exp=12,12", k0, k3); end
    n_checks++;
    if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
      n_errors++; $display("FAIL simul_model got=%h exp=%h", {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
    end
    sw = 4'hF;
    repeat (20) tick();
    sw[0] = 1'b0;
    repeat (7) begin tick(); if (press_o[0]) early++; end
    reset_n = 1'b0;
    model_reset();
    repeat (3) begin tick(); if (press_o[0]) early++; end
    n_checks++; if (early !== 0) begin n_errors++; $display("FAIL reset_mid_pulses got=%0d exp=0", early); end
    n_checks++; if ({db_o, toggle_o} !== 8'h00) begin n_errors++; $display("FAIL reset_mid_state got=%h exp=00", {db_o, toggle_o}); end
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_o[0] && kr < 0) kr = k;
    end
    n_checks++; if (kr !== 12) begin n_errors++; $display("FAIL reset_requalify got=%0d exp=12", kr); end
  endtask

  task automatic test_hold();
    int kp = -1, kh = -1, holds = 0;
    sw = 4'hF;
    repeat (20) tick();
    sw[1] = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      tick(); n_checks++;
      if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
        n_errors++; $display("FAIL hold_model got=%h exp=%h", {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
      end
      if (press_o[1] && kp < 0) kp = k;
      if (hold_o != '0) begin holds++; if (kh < 0) kh = k; end
    end
`ifdef DEBOUNCE_HOLD_EN
    n_checks++; if (kh - kp !== HOLD) begin n_errors++; $display("FAIL hold_delay got=%0d exp=%0d", kh - kp, HOLD); end
    n_checks++; if (holds !== 1) begin n_errors++; $display("FAIL hold_count got=%0d exp=1", holds); end
`else
    n_checks++; if (holds !== 0) begin n_errors++; $display("FAIL hold_absent got=%0d exp=0", holds); end
`endif
    sw = 4'hF;
    repeat (20) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 7) == 0) sw[c] = ~sw[c];
      tick(); n_checks++;
      if ({db_o, press_o, release_o, toggle_o, hold_o} !== {m_db, m_press, m_rel, m_tog, m_hold}) begin
        n_errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", k, {db_o, press_o, release_o, toggle_o, hold_o}, {m_db, m_press, m_rel, m_tog, m_hold});
      end
      n_checks++;
      if ((press_o & release_o) !== '0) begin
        n_errors++; $display("FAIL random_press_and_release cyc=%0d got=%h exp=0", k, press_o & release_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_toggle();
    test_simultaneous_reset();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
